// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR chain and its downstream stages.
package fir_pkg;

   localparam int unsigned FIR_DATA_W = 8;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_decim_if.sv
// Sample stream in from the FIR and decimated valid/ready stream out.
interface fir_decim_if #(
   parameter int unsigned DATA_W = fir_pkg::FIR_DATA_W
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/fir_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO
// becomes visible on the following cycle.
module fir_fifo import fir_pkg::*; #(
   parameter int unsigned DATA_W = FIR_DATA_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [clog2(DEPTH):0] level_o,
   output logic [DATA_W-1:0]     rdata_o
);
   localparam int unsigned PtrW = clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]   level_q, level_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              do_push, do_pop;

   assign full_o  = (level_q == LvlW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = head_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         level_d = level_q + LvlW'(1);
      end else if (do_pop && !do_push) begin
         level_d = level_q - LvlW'(1);
      end
      // Head takes the new word when it becomes the only entry, else the next stored one.
      if (do_push && (empty_o || (do_pop && level_q == LvlW'(1)))) begin
         head_d = wdata_i;
      end else if (do_pop && level_q > LvlW'(1)) begin
         head_d = mem_q[rd_ptr_q + PtrW'(1)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end
endmodule

// File: rtl/fir_decim.sv
// Block-average decimator: sums DECIM valid samples, rounds half-up and
// queues the mean for a stallable consumer, flagging results lost to a full FIFO.
module fir_decim import fir_pkg::*; #(
   parameter int unsigned DATA_W = FIR_DATA_W,
   parameter int unsigned DECIM  = 4,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   fir_decim_if.slave            bus,
   output logic [clog2(DEPTH):0] level,
   output logic                  overflow
);
   localparam int unsigned Log2D  = clog2(DECIM);
   localparam int unsigned AccW   = DATA_W + Log2D;
   localparam int unsigned PhaseW = Log2D;

   logic [AccW-1:0]   acc_q, acc_d, sum, rnd;
   logic [PhaseW-1:0] phase_q, phase_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] result, head;
   logic              produce, pop, full, empty;

   always_comb begin
      acc_d      = acc_q;
      phase_d    = phase_q;
      produce    = 1'b0;
      sum        = acc_q + AccW'(bus.in_data);
      rnd        = sum + AccW'(DECIM / 2);
      result     = DATA_W'(rnd >> Log2D);
      pop        = bus.out_valid && bus.out_ready;
      if (bus.in_valid) begin
         if (phase_q == PhaseW'(DECIM - 1)) begin
            produce = 1'b1;
            acc_d   = '0;
            phase_d = '0;
         end else begin
            acc_d   = sum;
            phase_d = phase_q + PhaseW'(1);
         end
      end
      // A pop on the same edge makes room, so only an unrelieved full FIFO drops.
      overflow_d = overflow_q || (produce && full && !pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q      <= '0;
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         phase_q    <= phase_d;
         overflow_q <= overflow_d;
      end
   end

   fir_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (produce),
      .wdata_i (result),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level),
      .rdata_o (head)
   );

   assign bus.out_valid = !empty;
   assign bus.out_data  = head;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: rounding, gaps, back-pressure, overflow and reset.
module tb_fir_decim;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] level;
   logic       overflow;
   int         checks = 0;
   int         passes = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   fir_decim_if #(.DATA_W(8)) bus ();

   fir_decim #(
      .DATA_W (8),
      .DECIM  (4),
      .DEPTH  (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   // Records the head if it will be popped at the coming edge, then advances one cycle.
   task automatic send(input logic v, input logic [7:0] d);
      bus.in_valid = v;
      bus.in_data  = d;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      send(1'b0, 8'd0);
      send(1'b0, 8'd0);
      reset = 1'b0;
      got.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
      end
      got.delete();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      do_reset();
      check("rst level", level, 0);
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_data", bus.out_data, 0);
      check("rst overflow", overflow, 0);

      // 10..13 -> (46+2)>>2 = 12, valid for exactly one cycle
      send(1'b1, 8'd10);
      send(1'b1, 8'd11);
      send(1'b1, 8'd12);
      check("t1 early valid", bus.out_valid, 0);
      send(1'b1, 8'd13);
      check("t1 valid", bus.out_valid, 1);
      check("t1 data", bus.out_data, 12);
      send(1'b0, 8'd0);
      check("t1 valid drop", bus.out_valid, 0);
      exp_q = {8'd12};
      check_outputs("t1");

      // Max and min values
      for (int i = 0; i < 8; i++) send(1'b1, 8'd255);
      for (int i = 0; i < 8; i++) send(1'b1, 8'd1);
      for (int i = 0; i < 4; i++) send(1'b0, 8'd0);
      exp_q = {8'd255, 8'd255, 8'd1, 8'd1};
      check_outputs("t2");
      check("t2 overflow", overflow, 0);

      // Gapped input: 4+4+4+5 = 17 -> 4; data during gaps must be ignored
      send(1'b1, 8'd4);
      send(1'b0, 8'd200);
      send(1'b0, 8'd200);
      send(1'b1, 8'd4);
      send(1'b1, 8'd4);
      send(1'b0, 8'd200);
      send(1'b1, 8'd5);
      for (int i = 0; i < 3; i++) send(1'b0, 8'd0);
      exp_q = {8'd4};
      check_outputs("t3");

      // Stalled consumer: blocks 1..5, fifth is dropped
      bus.out_ready = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         for (int i = 0; i < 4; i++) send(1'b1, 8'(b));
      end
      check("t4 level", level, 4);
      check("t4 overflow", overflow, 1);
      check("t4 head", bus.out_data, 1);
      send(1'b0, 8'd0);
      check("t4 head stable", bus.out_data, 1);
      check("t4 valid stable", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) send(1'b0, 8'd0);
      exp_q = {8'd1, 8'd2, 8'd3, 8'd4};
      check_outputs("t4");
      check("t4 drained level", level, 0);
      check("t4 overflow sticky", overflow, 1);

      // Push and pop on the same edge while full
      do_reset();
      bus.out_ready = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         for (int i = 0; i < 4; i++) send(1'b1, 8'(10 * b));
      end
      check("t5 full level", level, 4);
      for (int i = 0; i < 3; i++) send(1'b1, 8'd50);
      bus.out_ready = 1'b1;
      send(1'b1, 8'd50);
      check("t5 level", level, 4);
      check("t5 overflow", overflow, 0);
      check("t5 head", bus.out_data, 20);
      for (int i = 0; i < 6; i++) send(1'b0, 8'd0);
      exp_q = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
      check_outputs("t5");
      check("t5 end level", level, 0);

      // Reset mid-block discards the partial sum
      send(1'b1, 8'd100);
      send(1'b1, 8'd100);
      reset = 1'b1;
      send(1'b1, 8'd200);
      check("t6 rst level", level, 0);
      check("t6 rst valid", bus.out_valid, 0);
      check("t6 rst overflow", overflow, 0);
      reset = 1'b0;
      send(1'b0, 8'd0);
      check("t6 post level", level, 0);
      check("t6 post valid", bus.out_valid, 0);
      check("t6 post overflow", overflow, 0);
      for (int i = 0; i < 4; i++) send(1'b1, 8'd8);
      for (int i = 0; i < 3; i++) send(1'b0, 8'd0);
      exp_q = {8'd8};
      check_outputs("t6");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
